lc3_mmio: RTL
=============

Name: lc3_mmio

Overview:
- Memory-mapped I/O stage between the LC-3 core's memory port (mar, mdr, memwe) and the data memory.
- Decodes the LC-3 device page and implements the KBSR, KBDR, DSR, DDR and MCR registers.
- Buffers keyboard characters in a small FIFO and drives the display through a valid/ready handshake.
- Steers read data back to the core and blocks device-page writes from reaching memory.

Parameters:
- KB_DEPTH, 4: keyboard FIFO depth in entries; power of 2, at least 2.
- DEV_BASE, 16'hFE00: base address of the device page; KBSR=+0, KBDR=+2, DSR=+4, DDR=+6; MCR fixed at 16'hFFFE.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mar  in  16  address from the core.
- mdr  in  16  write data from the core.
- memwe  in  1  write strobe from the core, one cycle per store.
- memre  in  1  read-commit strobe; one cycle when the core latches the read data.
- mem_rdata  in  16  read data from the data memory.
- cpu_rdata  out  16  read data returned to the core.
- mem_we  out  1  write enable forwarded to the data memory.
- kb_valid  in  1  keyboard character offered.
- kb_data  in  8  keyboard character.
- kb_ready  out  1  FIFO can accept a character.
- dsp_valid  out  1  display character pending.
- dsp_data  out  8  display character.
- dsp_ready  in  1  display accepts the character.
- kb_irq  out  1  keyboard interrupt request.
- dsp_irq  out  1  display interrupt request.
- run  out  1  core clock enable; equals MCR[15].
- dsp_drop_cnt  out  8  count of DDR writes lost while the display was busy; saturating.

Behaviour:
- Decode: dev_hit when mar equals one of the 5 register addresses. Other addresses in the page are not hits and go to memory.
- mem_we = memwe & ~dev_hit. Combinational, zero latency.
- cpu_rdata is combinational: the selected register when dev_hit, otherwise mem_rdata.
- KBSR read value = {fifo_nonempty, kb_ie, 14'b0}.
- KBDR read value = {8'h00, FIFO head}; reads 16'h0000 when the FIFO is empty.
- DSR read value = {~dsp_valid, dsp_ie, 14'b0}.
- DDR read value = {8'h00, dsp_data}.
- MCR read value = the mcr register.
- Keyboard FIFO:
  - kb_ready = ~full. Readiness is never pop-adjusted.
  - Push on kb_valid & kb_ready.
  - Pop on memre & mar==KBDR & nonempty. A pop of an empty FIFO does nothing.
  - Simultaneous push and pop when not full: both happen and the count is unchanged.
  - Pointers wrap modulo KB_DEPTH. Order is FIFO.
- Display:
  - A store to DDR while dsp_valid==0 loads dsp_data=mdr[7:0] and sets dsp_valid=1 on the next edge.
  - dsp_valid clears on the edge where dsp_valid & dsp_ready.
  - A store to DDR while dsp_valid==1 is dropped and dsp_drop_cnt increments, saturating at 8'hFF.
  - A store in the same cycle as the handshake completion is also dropped, because the status was busy when the store was issued.
- KBSR/DSR stores write only bit 14 (kb_ie / dsp_ie). All other bits are read-only.
- KBDR stores are ignored.
- MCR store writes all 16 bits.
- kb_irq = fifo_nonempty & kb_ie. dsp_irq = ~dsp_valid & dsp_ie. Both combinational from registers.
- Reset (asynchronous, any time, including mid-handshake):
  - FIFO empty, so kb_ready=1.
  - dsp_valid=0, dsp_data=0.
  - kb_ie=dsp_ie=0.
  - mcr=16'h8000, so run=1.
  - dsp_drop_cnt=0.
  - Irqs therefore 0.
  - cpu_rdata/mem_we follow the inputs combinationally.
- All register updates occur on rising clk.

Test Plan:
- Reset, then mar=16'h3000, memwe=1, mdr=16'h1234 -> mem_we=1, cpu_rdata=mem_rdata; run=1, kb_ready=1, dsp_valid=0, irqs 0.
- Push 'A','B','C','D' (kb_valid held) -> kb_ready=0 after the 4th; KBSR reads 16'h8000. Four memre reads of KBDR -> 16'h0041..16'h0044 in order. A fifth read -> 16'h0000 and KBSR=16'h0000.
- Store 16'h4000 to KBSR, then push 'Z' -> kb_irq=1 the cycle after the push. Read-pop KBDR -> kb_irq=0 the next cycle.
- dsp_ready=0; store 16'h0048 to DDR -> dsp_valid=1, dsp_data=8'h48, mem_we=0, DSR=16'h0000. Second DDR store -> dsp_drop_cnt=1, dsp_data still 8'h48. Raise dsp_ready one cycle -> dsp_valid=0, DSR=16'h8000.
- Store 16'h0000 to MCR -> run=0 next cycle. Assert reset asynchronously mid-display-handshake -> run=1, dsp_valid=0, dsp_drop_cnt=0 immediately.
- Simultaneous kb_valid push and KBDR pop with FIFO holding 2 entries -> count stays 2; the head advances correctly across the pointer wrap.

Source files
------------

// File: rtl/lc3_mmio_if.sv
// lc3_mmio_if: core memory port, data memory, keyboard, display, interrupt and run-control signals
interface lc3_mmio_if;
   logic [15:0] mar;
   logic [15:0] mdr;
   logic        memwe;
   logic        memre;
   logic [15:0] mem_rdata;
   logic [15:0] cpu_rdata;
   logic        mem_we;
   logic        kb_valid;
   logic [7:0]  kb_data;
   logic        kb_ready;
   logic        dsp_valid;
   logic [7:0]  dsp_data;
   logic        dsp_ready;
   logic        kb_irq;
   logic        dsp_irq;
   logic        run;
   logic [7:0]  dsp_drop_cnt;
   modport master (
      output mar, mdr, memwe, memre, mem_rdata, kb_valid, kb_data, dsp_ready,
      input  cpu_rdata, mem_we, kb_ready, dsp_valid, dsp_data, kb_irq, dsp_irq, run, dsp_drop_cnt
   );
   modport slave (
      input  mar, mdr, memwe, memre, mem_rdata, kb_valid, kb_data, dsp_ready,
      output cpu_rdata, mem_we, kb_ready, dsp_valid, dsp_data, kb_irq, dsp_irq, run, dsp_drop_cnt
   );
endinterface

// File: rtl/lc3_mmio.sv
// lc3_mmio: LC-3 device page decode with KBSR/KBDR/DSR/DDR/MCR, keyboard FIFO and display handshake
module lc3_mmio #(
   parameter int          KB_DEPTH = 4,
   parameter logic [15:0] DEV_BASE = 16'hFE00
) (
   input logic         clk,
   input logic         reset,
   lc3_mmio_if.slave   bus
);
   localparam int AW = $clog2(KB_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [15:0] A_KBSR = DEV_BASE;
   localparam logic [15:0] A_KBDR = DEV_BASE + 16'd2;
   localparam logic [15:0] A_DSR  = DEV_BASE + 16'd4;
   localparam logic [15:0] A_DDR  = DEV_BASE + 16'd6;
   localparam logic [15:0] A_MCR  = 16'hFFFE;

   logic [7:0]    r_mem [KB_DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [CW-1:0] r_cnt;
   logic          r_kb_ie, r_dsp_ie, r_dsp_valid;
   logic [7:0]    r_dsp_data, r_drop;
   logic [15:0]   r_mcr;

   logic w_kbsr, w_kbdr, w_dsr, w_ddr, w_mcr, w_hit;
   logic w_empty, w_full, w_push, w_pop, w_ddr_wr;
   logic [15:0] w_rdata;

   assign w_kbsr   = bus.mar == A_KBSR;
   assign w_kbdr   = bus.mar == A_KBDR;
   assign w_dsr    = bus.mar == A_DSR;
   assign w_ddr    = bus.mar == A_DDR;
   assign w_mcr    = bus.mar == A_MCR;
   assign w_hit    = w_kbsr | w_kbdr | w_dsr | w_ddr | w_mcr;
   assign w_empty  = r_cnt == '0;
   assign w_full   = r_cnt == CW'(KB_DEPTH);
   assign w_push   = bus.kb_valid & ~w_full;
   assign w_pop    = bus.memre & w_kbdr & ~w_empty;
   assign w_ddr_wr = bus.memwe & w_ddr;

   always_comb begin
      w_rdata = w_kbsr ? {~w_empty, r_kb_ie, 14'b0} :
                w_kbdr ? (w_empty ? 16'h0000 : {8'h00, r_mem[r_rp]}) :
                w_dsr  ? {~r_dsp_valid, r_dsp_ie, 14'b0} :
                w_ddr  ? {8'h00, r_dsp_data} :
                w_mcr  ? r_mcr : bus.mem_rdata;
   end

   assign bus.cpu_rdata    = w_rdata;
   assign bus.mem_we       = bus.memwe & ~w_hit;
   assign bus.kb_ready     = ~w_full;
   assign bus.dsp_valid    = r_dsp_valid;
   assign bus.dsp_data     = r_dsp_data;
   assign bus.kb_irq       = ~w_empty & r_kb_ie;
   assign bus.dsp_irq      = ~r_dsp_valid & r_dsp_ie;
   assign bus.run          = r_mcr[15];
   assign bus.dsp_drop_cnt = r_drop;

   always_ff @(posedge clk)
      if (w_push) r_mem[r_wp] <= bus.kb_data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wp        <= '0;
         r_rp        <= '0;
         r_cnt       <= '0;
         r_kb_ie     <= 1'b0;
         r_dsp_ie    <= 1'b0;
         r_dsp_valid <= 1'b0;
         r_dsp_data  <= 8'h00;
         r_drop      <= 8'h00;
         r_mcr       <= 16'h8000;
      end else begin
         if (w_push) r_wp <= r_wp + AW'(1);
         if (w_pop) r_rp <= r_rp + AW'(1);
         r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
         if (bus.memwe & w_kbsr) r_kb_ie <= bus.mdr[14];
         if (bus.memwe & w_dsr) r_dsp_ie <= bus.mdr[14];
         if (bus.memwe & w_mcr) r_mcr <= bus.mdr;
         // a store seen while busy is lost, even if the handshake completes on this edge
         if (r_dsp_valid & bus.dsp_ready) r_dsp_valid <= 1'b0;
         else if (w_ddr_wr & ~r_dsp_valid) begin
            r_dsp_valid <= 1'b1;
            r_dsp_data  <= bus.mdr[7:0];
         end
         if (w_ddr_wr & r_dsp_valid & (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
      end
   end
endmodule
